multicycle_control: RTL and testbench

Parametrised multicycle control unit for the RV32I core. It sequences fetch, decode, execute, memory and writeback for all RV32I base integer opcodes except SYSTEM and FENCE, and drives every datapath load enable, mux select and memory strobe. Compared with the fetch-only sequencer it adds:
- memory-wait timeout
- fault detection (illegal opcode, misaligned access, timeout)
- registered byte enables
- a retired-instruction counter

---
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control.sv | 173 +++++++++++++++++
 tb/tb_multicycle_control.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: IR fields, memory handshake and datapath controls between sequencer and datapath
// master = sequencer (drives controls/strobes/status), slave = datapath/memory side
interface multicycle_control_if #(parameter int CNT_W = 32);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [1:0] addr_lsb;
  logic br_taken;
  logic mem_resp;
  logic load_mar;
  logic load_mdr;
  logic load_pc;
  logic load_ir;
  logic load_regfile;
  logic [1:0] pc_mux_sel;
  logic mdr_mux_sel;
  logic [1:0] databus_mux_sel;
  logic alu_a_sel;
  logic [1:0] alu_b_sel;
  logic [1:0] alu_mode;
  logic mem_read;
  logic mem_write;
  logic [3:0] mem_byte_en;
  logic fault;
  logic [1:0] fault_cause;
  logic [CNT_W-1:0] instret;
  modport master (
    input opcode, funct3, addr_lsb, br_taken, mem_resp,
    output load_mar, load_mdr, load_pc, load_ir, load_regfile, pc_mux_sel, mdr_mux_sel,
      databus_mux_sel, alu_a_sel, alu_b_sel, alu_mode, mem_read, mem_write, mem_byte_en,
      fault, fault_cause, instret
  );
  modport slave (
    output opcode, funct3, addr_lsb, br_taken, mem_resp,
    input load_mar, load_mdr, load_pc, load_ir, load_regfile, pc_mux_sel, mdr_mux_sel,
      databus_mux_sel, alu_a_sel, alu_b_sel, alu_mode, mem_read, mem_write, mem_byte_en,
      fault, fault_cause, instret
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multicycle sequencer with memory timeout, fault detection, byte enables and instret
// ports: clk, rst_n (async active-low), bus (master side of multicycle_control_if)
module multicycle_control #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst_n,
  multicycle_control_if.master bus
);
  localparam int WW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(MEM_TIMEOUT - 1);
  typedef enum logic [3:0] {
    FETCH_0, FETCH_1, FETCH_2, DECODE, EXEC_ALU, EXEC_BR, EXEC_JAL, EXEC_JALR,
    CALC_ADDR, LD_1, LD_2, ST_1, FAULT
  } state_t;
  state_t state, nxt;
  logic [WW-1:0] wait_cnt;
  logic [3:0] byte_en, byte_en_nxt;
  logic [1:0] cause, cause_nxt;
  logic faulted, retire, wait_inc, wait_clr, timed_out, misaligned, store;
  logic [CNT_W-1:0] instret;
  assign store = bus.opcode[5];
  assign timed_out = (MEM_TIMEOUT != 0) && (wait_cnt == W_LAST);
  assign misaligned = (bus.funct3[1:0] == 2'd2 && bus.addr_lsb != 2'd0) ||
                      (bus.funct3[1:0] == 2'd1 && bus.addr_lsb[0]);
  assign bus.mem_byte_en = byte_en;
  assign bus.fault = faulted;
  assign bus.fault_cause = cause;
  assign bus.instret = instret;
  always_comb begin
    nxt = state;
    cause_nxt = 2'd0;
    retire = 1'b0;
    wait_inc = 1'b0;
    wait_clr = 1'b0;
    byte_en_nxt = byte_en;
    bus.load_mar = 1'b0;
    bus.load_mdr = 1'b0;
    bus.load_pc = 1'b0;
    bus.load_ir = 1'b0;
    bus.load_regfile = 1'b0;
    bus.pc_mux_sel = 2'd0;
    bus.mdr_mux_sel = 1'b0;
    bus.databus_mux_sel = 2'd0;
    bus.alu_a_sel = 1'b0;
    bus.alu_b_sel = 2'd0;
    bus.alu_mode = 2'd0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    case (state)
      FETCH_0: begin
        bus.load_mar = 1'b1;
        bus.load_pc = 1'b1;
        bus.mem_read = 1'b1;
        byte_en_nxt = 4'hF;
        wait_clr = 1'b1;
        nxt = FETCH_1;
      end
      FETCH_1: begin
        bus.mem_read = 1'b1;
        bus.load_mdr = bus.mem_resp;
        wait_inc = 1'b1;
        cause_nxt = 2'd2;
        nxt = bus.mem_resp ? FETCH_2 : timed_out ? FAULT : FETCH_1;
      end
      FETCH_2: begin
        bus.load_ir = 1'b1;
        bus.databus_mux_sel = 2'd1;
        nxt = DECODE;
      end
      DECODE: begin
        cause_nxt = 2'd1;
        case (bus.opcode)
          7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: nxt = EXEC_ALU;
          7'b1100011: nxt = EXEC_BR;
          7'b1101111: nxt = EXEC_JAL;
          7'b1100111: nxt = EXEC_JALR;
          7'b0000011, 7'b0100011: nxt = CALC_ADDR;
          default: nxt = FAULT;
        endcase
      end
      EXEC_ALU: begin
        bus.load_regfile = 1'b1;
        bus.databus_mux_sel = 2'd2;
        bus.alu_a_sel = bus.opcode == 7'b0010111;
        bus.alu_b_sel = bus.opcode == 7'b0110011 ? 2'd0 : 2'd1;
        bus.alu_mode = bus.opcode == 7'b0110111 ? 2'd2 : bus.opcode == 7'b0010111 ? 2'd0 : 2'd1;
        retire = 1'b1;
        nxt = FETCH_0;
      end
      EXEC_BR: begin
        bus.alu_a_sel = 1'b1;
        bus.alu_b_sel = 2'd1;
        bus.pc_mux_sel = 2'd1;
        bus.load_pc = bus.br_taken;
        retire = 1'b1;
        nxt = FETCH_0;
      end
      EXEC_JAL, EXEC_JALR: begin
        // link value comes from PC, which already advanced to PC+4 during fetch
        bus.alu_a_sel = state == EXEC_JAL;
        bus.alu_b_sel = 2'd1;
        bus.pc_mux_sel = state == EXEC_JAL ? 2'd1 : 2'd2;
        bus.load_pc = 1'b1;
        bus.load_regfile = 1'b1;
        retire = 1'b1;
        nxt = FETCH_0;
      end
      CALC_ADDR: begin
        bus.alu_b_sel = 2'd1;
        bus.load_mar = 1'b1;
        bus.databus_mux_sel = 2'd2;
        bus.load_mdr = store;
        bus.mdr_mux_sel = store;
        wait_clr = 1'b1;
        cause_nxt = 2'd3;
        byte_en_nxt = misaligned ? byte_en : bus.funct3[1:0] == 2'd0 ? 4'b0001 << bus.addr_lsb :
                      bus.funct3[1:0] == 2'd1 ? 4'b0011 << bus.addr_lsb : 4'hF;
        nxt = misaligned ? FAULT : store ? ST_1 : LD_1;
      end
      LD_1: begin
        bus.mem_read = 1'b1;
        bus.load_mdr = bus.mem_resp;
        wait_inc = 1'b1;
        cause_nxt = 2'd2;
        nxt = bus.mem_resp ? LD_2 : timed_out ? FAULT : LD_1;
      end
      LD_2: begin
        bus.load_regfile = 1'b1;
        bus.databus_mux_sel = 2'd1;
        retire = 1'b1;
        nxt = FETCH_0;
      end
      ST_1: begin
        bus.mem_write = 1'b1;
        wait_inc = 1'b1;
        cause_nxt = 2'd2;
        retire = bus.mem_resp;
        nxt = bus.mem_resp ? FETCH_0 : timed_out ? FAULT : ST_1;
      end
      default: nxt = FAULT;
    endcase
    if (!rst_n) begin
      bus.load_mar = 1'b0;
      bus.load_mdr = 1'b0;
      bus.load_pc = 1'b0;
      bus.load_ir = 1'b0;
      bus.load_regfile = 1'b0;
      bus.mem_read = 1'b0;
      bus.mem_write = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH_0;
      wait_cnt <= '0;
      byte_en <= 4'h0;
      faulted <= 1'b0;
      cause <= 2'd0;
      instret <= '0;
    end else begin
      state <= nxt;
      wait_cnt <= wait_clr ? '0 : wait_inc ? wait_cnt + 1'b1 : wait_cnt;
      byte_en <= byte_en_nxt;
      if (nxt == FAULT && state != FAULT) begin
        faulted <= 1'b1;
        cause <= cause_nxt;
      end
      if (retire) instret <= instret + 1'b1;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed-vector bench for multicycle_control with MEM_TIMEOUT=4
module tb_multicycle_control;
  logic clk;
  logic rst_n;
  int n_chk = 0;
  int n_pass = 0;
  multicycle_control_if #(.CNT_W(32)) bus ();
  multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [16:0] ctl;
  assign ctl = {bus.load_mar, bus.load_mdr, bus.load_pc, bus.load_ir, bus.load_regfile,
                bus.pc_mux_sel, bus.mdr_mux_sel, bus.databus_mux_sel, bus.alu_a_sel,
                bus.alu_b_sel, bus.alu_mode, bus.mem_read, bus.mem_write};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end
  function automatic logic [16:0] sig(input logic lm, ldr, lpc, lir, lrf, input logic [1:0] pcm,
                                       input logic mdrm, input logic [1:0] db, input logic a,
                                       input logic [1:0] b, md, input logic rd, wr);
    return {lm, ldr, lpc, lir, lrf, pcm, mdrm, db, a, b, md, rd, wr};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic cyc(input string tag, input logic resp, input logic [16:0] exp);
    bus.mem_resp = resp;
    #1;
    check(tag, 32'(ctl), 32'(exp));
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [6:0] op, input logic [2:0] f3);
    bus.opcode = op;
    bus.funct3 = f3;
    cyc("fetch0", 1'b0, sig(1,0,1,0,0,0,0,0,0,0,0,1,0));
    cyc("fetch1", 1'b1, sig(0,1,0,0,0,0,0,0,0,0,0,1,0));
    cyc("fetch2", 1'b0, sig(0,0,0,1,0,0,0,1,0,0,0,0,0));
    cyc("decode", 1'b0, 17'd0);
  endtask
  task automatic do_reset;
    bus.mem_resp = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic run_addi(input logic [31:0] ir0);
    fetch(7'b0010011, 3'b000);
    check("addi_instret_pre", bus.instret, ir0);
    cyc("exec_alu", 1'b0, sig(0,0,0,0,1,0,0,2,0,1,1,0,0));
    check("addi_instret_post", bus.instret, ir0 + 1);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.opcode = 7'b0010011;
    bus.funct3 = 3'b000;
    bus.addr_lsb = 2'd0;
    bus.br_taken = 1'b0;
    bus.mem_resp = 1'b0;
    #2;
    check("rst_ctl", 32'(ctl), 32'd0);
    check("rst_instret", bus.instret, 32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    check("rst_cause", 32'(bus.fault_cause), 32'd0);
    check("rst_byte_en", 32'(bus.mem_byte_en), 32'd0);
    @(posedge clk);
    #1;
    check("rst_ctl_held", 32'(ctl), 32'd0);
    rst_n = 1'b1;
    run_addi(32'd0);
    bus.addr_lsb = 2'd2;
    fetch(7'b0000011, 3'b001);
    cyc("lh_calc", 1'b0, sig(1,0,0,0,0,0,0,2,0,1,0,0,0));
    check("lh_byte_en", 32'(bus.mem_byte_en), 32'hC);
    cyc("lh_ld1_wait", 1'b0, sig(0,0,0,0,0,0,0,0,0,0,0,1,0));
    check("lh_byte_en_hold", 32'(bus.mem_byte_en), 32'hC);
    cyc("lh_ld1_resp", 1'b1, sig(0,1,0,0,0,0,0,0,0,0,0,1,0));
    cyc("lh_ld2", 1'b0, sig(0,0,0,0,1,0,0,1,0,0,0,0,0));
    check("lh_instret", bus.instret, 32'd2);
    bus.addr_lsb = 2'd1;
    fetch(7'b0000011, 3'b001);
    cyc("lh_mis_calc", 1'b0, sig(1,0,0,0,0,0,0,2,0,1,0,0,0));
    cyc("lh_mis_fault", 1'b1, 17'd0);
    check("lh_mis_flag", 32'(bus.fault), 32'd1);
    check("lh_mis_cause", 32'(bus.fault_cause), 32'd3);
    check("lh_mis_instret", bus.instret, 32'd2);
    do_reset;
    bus.addr_lsb = 2'd0;
    fetch(7'b0100011, 3'b010);
    cyc("sw_calc", 1'b0, sig(1,1,0,0,0,0,1,2,0,1,0,0,0));
    for (int i = 0; i < 4; i++) cyc("sw_wait", 1'b0, sig(0,0,0,0,0,0,0,0,0,0,0,0,1));
    cyc("sw_timeout_fault", 1'b0, 17'd0);
    check("sw_to_flag", 32'(bus.fault), 32'd1);
    check("sw_to_cause", 32'(bus.fault_cause), 32'd2);
    check("sw_to_instret", bus.instret, 32'd0);
    do_reset;
    fetch(7'b0100011, 3'b010);
    cyc("sw2_calc", 1'b0, sig(1,1,0,0,0,0,1,2,0,1,0,0,0));
    check("sw2_byte_en", 32'(bus.mem_byte_en), 32'hF);
    for (int i = 0; i < 3; i++) cyc("sw2_wait", 1'b0, sig(0,0,0,0,0,0,0,0,0,0,0,0,1));
    cyc("sw2_resp", 1'b1, sig(0,0,0,0,0,0,0,0,0,0,0,0,1));
    check("sw2_no_fault", 32'(bus.fault), 32'd0);
    check("sw2_instret", bus.instret, 32'd1);
    do_reset;
    bus.br_taken = 1'b0;
    fetch(7'b1100011, 3'b000);
    cyc("beq_nt", 1'b0, sig(0,0,0,0,0,1,0,0,1,1,0,0,0));
    check("beq_nt_instret", bus.instret, 32'd1);
    bus.br_taken = 1'b1;
    fetch(7'b1100011, 3'b000);
    cyc("beq_t", 1'b0, sig(0,0,1,0,0,1,0,0,1,1,0,0,0));
    check("beq_t_instret", bus.instret, 32'd2);
    bus.br_taken = 1'b0;
    fetch(7'b1100111, 3'b000);
    cyc("jalr", 1'b0, sig(0,0,1,0,1,2,0,0,0,1,0,0,0));
    check("jalr_instret", bus.instret, 32'd3);
    fetch(7'b1110011, 3'b000);
    check("sys_fault", 32'(bus.fault), 32'd1);
    check("sys_cause", 32'(bus.fault_cause), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc("sys_sticky_ctl", 1'(i % 2), 17'd0);
      check("sys_sticky_fault", {30'd0, bus.fault, 1'b0} | 32'(bus.fault_cause), 32'h3);
    end
    check("sys_instret", bus.instret, 32'd3);
    do_reset;
    run_addi(32'd0);
    bus.addr_lsb = 2'd0;
    fetch(7'b0000011, 3'b010);
    cyc("lw_calc", 1'b0, sig(1,0,0,0,0,0,0,2,0,1,0,0,0));
    bus.mem_resp = 1'b0;
    #1;
    check("lw_ld1_pre", 32'(ctl), 32'(sig(0,0,0,0,0,0,0,0,0,0,0,1,0)));
    rst_n = 1'b0;
    #1;
    check("midrst_ctl", 32'(ctl), 32'd0);
    check("midrst_instret", bus.instret, 32'd0);
    check("midrst_byte_en", 32'(bus.mem_byte_en), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_addi(32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
